// File: rtl/pipeline_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_reg
// Purpose  : Generic inter-stage register with valid/ready handshake and a
//            two-entry skid buffer, flush with bubble injection and a
//            saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_reg #(
  parameter int                CTRL_W      = 8,
  parameter int                DATA_W      = 101,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_one   = 2'd1;
  localparam logic [1:0] c_st_two   = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall;

  logic w_out_valid;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  // Ready depends only on held state, so backpressure never forms a
  // combinational path from downstream to upstream.
  assign w_in_ready  = (r_state != c_st_two);
  assign w_out_valid = (r_state == c_st_one) || (r_state == c_st_two);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_st_empty;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_stall     <= '0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall != c_cnt_max))
        r_stall <= r_stall + c_cnt_one;

      if (flush) begin
        r_state <= c_st_empty;
      end else begin
        case (r_state)
          c_st_empty: begin
            if (w_in_fire) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
              r_state     <= c_st_one;
            end
          end
          c_st_one: begin
            if (w_in_fire && w_out_fire) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end else if (w_out_fire) begin
              r_state <= c_st_empty;
            end else if (w_in_fire) begin
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
              r_state     <= c_st_two;
            end
          end
          c_st_two: begin
            if (w_out_fire) begin
              r_main_ctrl <= r_skid_ctrl;
              r_main_data <= r_skid_data;
              r_state     <= c_st_one;
            end
          end
          default: r_state <= c_st_empty;
        endcase
      end
    end
  end

  // Gate outputs so a stale write enable never reaches the next stage.
  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_ctrl    = w_out_valid ? r_main_ctrl : BUBBLE_CTRL;
  assign out_data    = w_out_valid ? r_main_data : '0;
  assign stall_count = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_reg.sv
`default_nettype none
// Bench for pipeline_stage_reg: queue-based reference model plus directed
// vectors with literal expectations.
module tb_pipeline_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 101;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready,  in_ready2;
  logic              out_valid, out_valid2;
  logic [CTRL_W-1:0] out_ctrl,  out_ctrl2;
  logic [DATA_W-1:0] out_data,  out_data2;
  logic [15:0]       stall_count;
  logic [3:0]        stall_count2;

  pipeline_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_count(stall_count)
  );

  pipeline_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
    .out_data(out_data2), .stall_count(stall_count2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the block behaves as a FIFO of depth two.
  typedef struct { logic [CTRL_W-1:0] c; logic [DATA_W-1:0] d; } entry_t;
  entry_t m_q[$];
  int     m_stall;
  int     m_stall4;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_stall  = 0;
      m_stall4 = 0;
    end else begin
      automatic bit     ov = (m_q.size() > 0);
      automatic bit     ir = (m_q.size() < 2);
      automatic entry_t e;
      e.c = in_ctrl;
      e.d = in_data;
      if (ov && !out_ready) begin
        if (m_stall  < 65535) m_stall++;
        if (m_stall4 < 15)    m_stall4++;
      end
      if (flush) m_q.delete();
      else begin
        if (ov && out_ready) void'(m_q.pop_front());
        if (in_valid && ir) m_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    automatic bit                ev = (m_q.size() > 0);
    automatic logic [CTRL_W-1:0] ec = ev ? m_q[0].c : '0;
    automatic logic [DATA_W-1:0] ed = ev ? m_q[0].d : '0;
    chk("mdl_out_valid", out_valid, ev);
    chk("mdl_in_ready", in_ready, m_q.size() < 2);
    chk("mdl_out_ctrl", out_ctrl, ec);
    chk("mdl_out_data", out_data, ed);
    chk("mdl_stall", stall_count, m_stall);
    chk("mdl_stall4", stall_count2, m_stall4);
  end

  localparam logic [DATA_W-1:0] DA = 101'h0_1111_2222_3333_4444_5555_AAAA;
  localparam logic [DATA_W-1:0] DB = 101'h1_0000_BBBB_0000_BBBB_0000_BBBB;
  localparam logic [DATA_W-1:0] DC = 101'h0_CCCC_0000_CCCC_0000_CCCC_000C;
  localparam logic [DATA_W-1:0] DD = 101'h0_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_ctrl  = 'x;
    in_data  = 'x;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", out_ctrl, 8'h00);
    chk("rst_out_data", out_data, '0);
    chk("rst_stall", stall_count, 16'd0);

    // Streaming
    out_ready = 1'b1;
    push(8'h05, DA); step();
    chk("stream_a", out_data, DA);
    chk("stream_a_ctrl", out_ctrl, 8'h05);
    push(8'h05, DB); step();
    chk("stream_b", out_data, DB);
    push(8'h05, DC); step();
    chk("stream_c", out_data, DC);
    chk("stream_in_ready", in_ready, 1'b1);
    idle(); step();
    chk("stream_drained", out_valid, 1'b0);
    chk("stream_stall", stall_count, 16'd0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    push(8'h11, DA); step();
    push(8'h22, DB); step();
    idle();
    chk("bp_out_a", out_data, DA);
    chk("bp_in_ready", in_ready, 1'b0);
    repeat (3) step();
    chk("bp_stall", stall_count, 16'd4);
    out_ready = 1'b1; step();
    chk("bp_out_b", out_data, DB);
    chk("bp_out_b_ctrl", out_ctrl, 8'h22);
    chk("bp_ready_back", in_ready, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Flush while full with a concurrent offer
    out_ready = 1'b0;
    push(8'h33, DA); step();
    push(8'h44, DB); step();
    chk("fl_full", in_ready, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    push(8'h55, DD); step();
    flush = 1'b0; idle();
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_out_ctrl", out_ctrl, 8'h00);
    chk("fl_in_ready", in_ready, 1'b1);
    chk("fl_stall", stall_count, 16'd5);
    step();
    chk("fl_dropped", out_valid, 1'b0);

    // Saturation of the 4-bit counter
    out_ready = 1'b0;
    push(8'h66, DC); step();
    idle();
    repeat (20) step();
    chk("sat_4bit", stall_count2, 4'd15);
    chk("sat_16bit", stall_count, 16'd25);

    // Asynchronous reset between edges
    push(8'h77, DD); step();
    idle();
    chk("ar_two", in_ready, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_stall", stall_count, 16'd0);
    chk("ar_out_data", out_data, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    chk("ar_post", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one generic control bundle and one data bundle between two pipeline stages.
- Adds a valid/ready handshake, a two-entry skid buffer for registered backpressure, synchronous flush with bubble injection, and a saturating stall counter.
- Every stage boundary of the pipelined core is built by instantiating this block with different widths.

Parameters:
- CTRL_W, 8, width of control bundle (e.g. RegWrite, ResultSrc, MemWrite).
- DATA_W, 101, width of data bundle (e.g. ALUResult, ReadData, Rd, PCPlus4 concatenated).
- BUBBLE_CTRL, 0, control value presented whenever out_valid=0, after reset and after flush.
- CNT_W, 16, width of stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous flush: discards all held entries.
- in_valid  input  1  upstream stage offers an entry.
- in_ready  output  1  block can accept an entry; registered.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  out_ctrl/out_data hold a valid entry.
- out_ready  input  1  downstream stage consumes the entry.
- out_ctrl  output  CTRL_W  control bundle; equals BUBBLE_CTRL when out_valid=0.
- out_data  output  DATA_W  data bundle; all zeros when out_valid=0.
- stall_count  output  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. All storage is non-blocking and clocked on posedge clk.
- Reset (rst=0, asynchronous): state=EMPTY, out_valid=0, in_ready=1, out_ctrl=BUBBLE_CTRL, out_data=0, skid cleared, stall_count=0.
- in_ready is 1 in EMPTY and ONE, and 0 in TWO. It is a function of registered state only, with no combinational path from out_ready.
- Latency: an entry accepted at edge N appears on outputs after edge N when the block was EMPTY, or when it was ONE with out_fire.
- States:
  - EMPTY (no entries).
  - ONE (main valid).
  - TWO (main and skid valid).
- Transitions, checked in priority order:
  - flush=1: go to EMPTY from any state. Both entries and any concurrent in_fire are dropped. out_ctrl=BUBBLE_CTRL, out_data=0.
  - EMPTY, in_fire: main<=in, go to ONE.
  - EMPTY, no in_fire: stay EMPTY.
  - ONE, in_fire & out_fire: main<=in, stay ONE.
  - ONE, out_fire only: go to EMPTY, outputs go to bubble.
  - ONE, in_fire only: skid<=in, go to TWO.
  - ONE, neither: hold main.
  - TWO, out_fire: main<=skid, go to ONE. No input is accepted because in_ready=0.
  - TWO, no out_fire: hold both entries.
- Outputs while out_valid=0 are forced to BUBBLE_CTRL/zero, so no write enable ever leaks downstream.
- Ordering: entries leave in acceptance order. No entry is duplicated or lost except on flush.
- stall_count increments by 1 each cycle where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-transfer: all entries are discarded immediately, regardless of clk.
- X on in_ctrl/in_data while in_valid=0 must not propagate to outputs.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with in_valid=0 -> out_valid=0, out_ctrl=BUBBLE_CTRL(0), out_data=0, in_ready=1, stall_count=0.
- Streaming: out_ready=1, push ctrl=8'h05/data=A, B, C on consecutive cycles -> each appears one cycle later in order, in_ready stays 1, stall_count=0.
- Backpressure/skid: out_ready=0, push A then B -> out_data=A, in_ready=0 after B. Hold for 3 cycles -> stall_count=4. Set out_ready=1 -> A then B delivered, in_ready returns to 1.
- Flush with concurrent input: state TWO, assert flush with in_valid=1 (data=D) -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, D dropped, in_ready=1, stall_count unchanged.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_count stops at 15.
- Asynchronous reset mid-operation: in TWO, pull rst low between clock edges -> out_valid=0 and in_ready=1 immediately, before the next edge.
